p_ram_ctrl: RTL and testbench

Controller that sits between a parameter RAM and the DNN datapath. It serialises host write traffic into the RAM and sequences burst reads. Each burst starts at a base address, runs for a given length, and streams words to a MAC consumer over a valid/ready handshake. The RAM has a registered read address, giving one cycle of read latency; the controller hides that latency with a 2-entry output buffer, so it sustains 1 word/cycle.

---
 rtl/p_ram_ctrl_if.sv | 56 +++++
 rtl/p_ram_ctrl.sv | 135 +++++++++++++
 tb/tb_p_ram_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/p_ram_ctrl_if.sv
// Bundle of host-write, burst-read, stream and RAM-port signals around the
// parameter RAM controller. The controller uses the slave view; the host,
// consumer and RAM side together use the master view.
interface p_ram_ctrl_if #(
  parameter int unsigned D_WIDTH = 4,
  parameter int unsigned A_WIDTH = 4
);

  // Host write port
  logic               wr_req;
  logic [A_WIDTH-1:0] wr_addr;
  logic [D_WIDTH-1:0] wr_data;
  logic               wr_ack;

  // Burst read control
  logic               rd_start;
  logic [A_WIDTH-1:0] rd_base;
  logic [A_WIDTH:0]   rd_len;
  logic               rd_busy;
  logic               rd_done;

  // Word stream towards the MAC consumer
  logic               out_valid;
  logic               out_ready;
  logic [D_WIDTH-1:0] out_data;

  // Parameter RAM port (read address is registered inside the RAM)
  logic               ram_w_en;
  logic [A_WIDTH-1:0] ram_w_addr;
  logic [D_WIDTH-1:0] ram_data_in;
  logic [A_WIDTH-1:0] ram_r_addr;
  logic [D_WIDTH-1:0] ram_data_out;

  modport slave (
    input  wr_req, wr_addr, wr_data,
    output wr_ack,
    input  rd_start, rd_base, rd_len,
    output rd_busy, rd_done,
    output out_valid, out_data,
    input  out_ready,
    output ram_w_en, ram_w_addr, ram_data_in, ram_r_addr,
    input  ram_data_out
  );

  modport master (
    output wr_req, wr_addr, wr_data,
    input  wr_ack,
    output rd_start, rd_base, rd_len,
    input  rd_busy, rd_done,
    input  out_valid, out_data,
    output out_ready,
    input  ram_w_en, ram_w_addr, ram_data_in, ram_r_addr,
    output ram_data_out
  );

endinterface

// File: rtl/p_ram_ctrl.sv
// Parameter RAM controller: passes host writes into the RAM while idle and
// sequences burst reads, streaming one word per cycle to the MAC consumer.
// The RAM has one cycle of read latency; a 2-entry output buffer plus an
// in-flight flag hide it so the stream sustains full throughput.
module p_ram_ctrl #(
  parameter int unsigned D_WIDTH = 4,
  parameter int unsigned A_WIDTH = 4
) (
  input logic         clk,
  input logic         rst,
  p_ram_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDone
  } state_e;

  state_e             state_q;
  logic [A_WIDTH-1:0] ptr_q;         // next address to issue
  logic [A_WIDTH-1:0] raddr_q;       // last issued address, held between issues
  logic [A_WIDTH:0]   issue_left_q;  // addresses still to issue
  logic [A_WIDTH:0]   out_left_q;    // words still to hand to the consumer
  logic               inflight_q;    // a read was issued last cycle
  logic [D_WIDTH-1:0] buf_q [2];
  logic               head_q;
  logic [1:0]         count_q;

  logic       idle;
  logic       write_go;
  logic       start_go;
  logic       valid;
  logic       pop;
  logic       push;
  logic [2:0] occupancy;
  logic       issue;
  logic       wr_idx;
  logic       last_pop;

  // Handshake decode and issue throttle
  always_comb begin
    idle      = (state_q == StIdle);
    write_go  = bus.wr_req & rst & idle;
    // A same-cycle write wins over a burst request
    start_go  = bus.rd_start & ~bus.wr_req & idle;
    valid     = (count_q != 2'd0);
    pop       = valid & bus.out_ready;
    push      = inflight_q;
    // Slots committed after this cycle if nothing new is issued
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = (state_q == StStream) && (issue_left_q != '0) && (occupancy < 3'd2);
    // Push slot sits behind the head; count is at most 1 whenever a push lands
    wr_idx    = head_q ^ count_q[0];
    last_pop  = pop && (out_left_q == (A_WIDTH + 1)'(1));
  end

  assign bus.wr_ack      = write_go;
  assign bus.ram_w_en    = write_go;
  assign bus.ram_w_addr  = bus.wr_addr;
  assign bus.ram_data_in = bus.wr_data;
  assign bus.ram_r_addr  = issue ? ptr_q : raddr_q;
  assign bus.out_valid   = valid;
  assign bus.out_data    = valid ? buf_q[head_q] : '0;
  assign bus.rd_busy     = (state_q != StIdle);
  assign bus.rd_done     = (state_q == StDone);

  // Burst sequencer, read issue and output buffer
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      raddr_q      <= '0;
      issue_left_q <= '0;
      out_left_q   <= '0;
      inflight_q   <= 1'b0;
      buf_q[0]     <= '0;
      buf_q[1]     <= '0;
      head_q       <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      inflight_q <= issue;

      if (push) begin
        buf_q[wr_idx] <= bus.ram_data_out;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};

      unique case (state_q)
        StIdle: begin
          if (start_go) begin
            ptr_q        <= bus.rd_base;
            issue_left_q <= bus.rd_len;
            out_left_q   <= bus.rd_len;
            state_q      <= (bus.rd_len == '0) ? StDone : StStream;
          end
        end
        StStream: begin
          if (issue) begin
            ptr_q        <= ptr_q + A_WIDTH'(1);
            raddr_q      <= ptr_q;
            issue_left_q <= issue_left_q - (A_WIDTH + 1)'(1);
          end
          if (pop) begin
            out_left_q <= out_left_q - (A_WIDTH + 1)'(1);
          end
          if (last_pop) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Buffer must never be pushed while full without a matching pop
  a_no_overflow: assert property (@(posedge clk)
    (rst && inflight_q && (count_q == 2'd2)) |-> pop);

  // Count never exceeds the two physical slots
  a_count_range: assert property (@(posedge clk) rst |-> (count_q <= 2'd2));

  // A stalled word stays put until the consumer takes it
  a_stall_stable: assert property (@(posedge clk)
    (rst && valid && !bus.out_ready) |=> (valid && $stable(bus.out_data)));

endmodule

// File: tb/tb_p_ram_ctrl.sv
// Self-checking bench for p_ram_ctrl: a behavioural RAM, a burst-level
// reference model checked every cycle, directed latency/wrap/collision/reset
// cases with literal expectations, and a randomized traffic phase.
module tb_p_ram_ctrl;

  localparam int DW    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;

  p_ram_ctrl_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus ();

  p_ram_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural RAM with registered read address
  logic [DW-1:0] ram [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    bus.ram_data_out = '0;
    forever begin
      @(posedge clk);
      if (bus.ram_w_en) ram[bus.ram_w_addr] <= bus.ram_data_in;
      bus.ram_data_out <= ram[bus.ram_r_addr];
    end
  end

  // Consumer: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random
  int ready_mode = 0;
  initial begin
    int rphase;
    rphase = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       bus.out_ready = ((rphase % 3) == 0);
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b1;
      endcase
      rphase++;
    end
  end

  // Reference model: 0 idle, 1 bursting, 2 done cycle
  int            m_state = 0;
  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  bit            chk_en = 1'b0;
  bit            prev_stall = 1'b0;
  int            prev_data = 0;
  int            words_seen = 0;

  initial for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;

  // Compare DUT against the model every cycle, then advance the model
  always @(negedge clk) begin
    if (chk_en) begin : chk
      bit exp_wr;
      bit hs;
      int b;
      int l;
      exp_wr = bus.wr_req && rst && (m_state == 0);
      check("wr_ack", bus.wr_ack, exp_wr);
      check("ram_w_en", bus.ram_w_en, exp_wr);
      if (exp_wr) begin
        check("ram_w_addr", bus.ram_w_addr, bus.wr_addr);
        check("ram_data_in", bus.ram_data_in, bus.wr_data);
      end
      check("rd_busy", bus.rd_busy, m_state != 0);
      check("rd_done", bus.rd_done, m_state == 2);
      if (m_state != 1) check("out_valid_outside_burst", bus.out_valid, 0);
      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, prev_data);
      end
      hs = bus.out_valid && bus.out_ready && (m_state == 1);
      if (hs) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got word %0d, want no more words (t=%0t)",
                   bus.out_data, $time);
        end else begin
          check("out_data", bus.out_data, exp_q.pop_front());
          words_seen++;
        end
      end
      prev_stall = rst && bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (!rst) begin
        m_state = 0;
        exp_q.delete();
      end else begin
        case (m_state)
          0: begin
            if (exp_wr) begin
              exp_mem[bus.wr_addr] = bus.wr_data;
            end else if (bus.rd_start) begin
              b = int'(bus.rd_base);
              l = int'(bus.rd_len);
              for (int i = 0; i < l; i++) exp_q.push_back(exp_mem[(b + i) % DEPTH]);
              m_state = (l == 0) ? 2 : 1;
            end
          end
          1: if (hs && exp_q.size() == 0) m_state = 2;
          default: m_state = 0;
        endcase
      end
    end
  end

  // Stimulus helpers; all start and end at posedge+1
  task automatic wait_idle();
    int n = 0;
    while (m_state != 0) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 400) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout: got no burst end after %0d cycles, want end", n);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_write(input int addr, input int data, output int waited);
    bus.wr_req  = 1'b1;
    bus.wr_addr = AW'(addr);
    bus.wr_data = DW'(data);
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.wr_ack) break;
      waited++;
      if (waited > 400) begin
        checks++;
        errors++;
        $display("FAIL write_timeout: got no wr_ack after %0d cycles, want ack", waited);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    bus.wr_req = 1'b0;
  endtask

  task automatic start_burst(input int base, input int len);
    wait_idle();
    bus.rd_base  = AW'(base);
    bus.rd_len   = (AW + 1)'(len);
    bus.rd_start = 1'b1;
    @(posedge clk);
    #1;
    bus.rd_start = 1'b0;
  endtask

  // Full-throughput burst against an identity RAM image with literal timing
  task automatic directed_burst(input int base, input int len, input bit chk_addr,
                                input string tag);
    int first_v, done_c, nseen;
    int seen_d [16];
    int seen_c [16];
    int addr_s [16];
    wait_idle();
    bus.rd_base  = AW'(base);
    bus.rd_len   = (AW + 1)'(len);
    bus.rd_start = 1'b1;
    first_v = -1;
    done_c  = -1;
    nseen   = 0;
    for (int k = 0; k <= len + 5; k++) begin
      @(negedge clk);
      if (bus.out_valid && first_v < 0) first_v = k;
      if (bus.out_valid && bus.out_ready) begin
        if (nseen < 16) begin
          seen_d[nseen] = int'(bus.out_data);
          seen_c[nseen] = k;
        end
        nseen++;
      end
      if (bus.rd_done && done_c < 0) done_c = k;
      if (k >= 1 && k <= len) addr_s[k-1] = int'(bus.ram_r_addr);
      @(posedge clk);
      #1;
      if (k == 0) bus.rd_start = 1'b0;
    end
    if (len > 0) begin
      check({tag, "_first_valid_cycle"}, first_v, 3);
      check({tag, "_word_count"}, nseen, len);
      for (int i = 0; i < len && i < nseen; i++) begin
        check({tag, "_word"}, seen_d[i], (base + i) % DEPTH);
        check({tag, "_word_cycle"}, seen_c[i], 3 + i);
      end
      check({tag, "_done_cycle"}, done_c, 3 + len);
    end else begin
      check({tag, "_first_valid_cycle"}, first_v, -1);
      check({tag, "_done_cycle"}, done_c, 1);
    end
    if (chk_addr) begin
      for (int i = 0; i < len; i++) check({tag, "_r_addr"}, addr_s[i], (base + i) % DEPTH);
    end
    wait_idle();
  endtask

  initial begin
    int w;
    int op;
    int n0;
    int got [3];
    int ng;
    bus.wr_req   = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_start = 1'b0;
    bus.rd_base  = '0;
    bus.rd_len   = '0;

    // Reset state, with a write request that must stay gated
    repeat (2) @(posedge clk);
    #1;
    bus.wr_req  = 1'b1;
    bus.wr_addr = 4'd3;
    bus.wr_data = 4'd5;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_rd_busy", bus.rd_busy, 0);
    check("rst_rd_done", bus.rd_done, 0);
    check("rst_ram_r_addr", bus.ram_r_addr, 0);
    check("rst_ram_w_en", bus.ram_w_en, 0);
    check("rst_wr_ack", bus.wr_ack, 0);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_req = 1'b0;
    rst = 1'b1;

    // Identity image, then a full 16-word burst
    for (int i = 0; i < DEPTH; i++) begin
      do_write(i, i, w);
      check("init_write_wait", w, 0);
    end
    directed_burst(0, 16, 1'b1, "full");

    // Address wrap
    directed_burst(14, 4, 1'b1, "wrap");

    // Backpressure, plus rd_start pulses while busy that must be ignored
    ready_mode = 1;
    n0 = words_seen;
    start_burst(3, 6);
    bus.rd_base  = 4'd0;
    bus.rd_len   = 5'd1;
    bus.rd_start = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bus.rd_start = 1'b0;
    wait_idle();
    check("bp_word_count", words_seen - n0, 6);
    ready_mode = 0;

    // Same-cycle write and burst request: write wins, burst follows
    wait_idle();
    bus.wr_req   = 1'b1;
    bus.wr_addr  = 4'd7;
    bus.wr_data  = 4'd9;
    bus.rd_start = 1'b1;
    bus.rd_base  = 4'd6;
    bus.rd_len   = 5'd3;
    @(negedge clk);
    check("coll_wr_ack", bus.wr_ack, 1);
    @(posedge clk);
    #1;
    bus.wr_req = 1'b0;
    @(negedge clk);
    check("coll_busy_accept_cycle", bus.rd_busy, 0);
    @(posedge clk);
    #1;
    bus.rd_start = 1'b0;
    ng = 0;
    for (int k = 0; k < 20 && ng < 3; k++) begin
      @(negedge clk);
      if (k == 0) check("coll_busy_next", bus.rd_busy, 1);
      if (bus.out_valid && bus.out_ready) begin
        got[ng] = int'(bus.out_data);
        ng++;
      end
      @(posedge clk);
      #1;
    end
    check("coll_words", ng, 3);
    if (ng == 3) begin
      check("coll_word0", got[0], 6);
      check("coll_word1", got[1], 9);
      check("coll_word2", got[2], 8);
    end
    wait_idle();

    // Write during a stream stalls until idle, then lands
    ready_mode = 1;
    start_burst(0, 8);
    do_write(2, 5, w);
    check("stream_write_stalled", (w > 0) ? 1 : 0, 1);
    ready_mode = 0;
    start_burst(2, 1);
    wait_idle();
    do_write(2, 2, w);
    do_write(7, 7, w);

    // Zero-length burst, and a full wrap from base 5
    directed_burst(0, 0, 1'b0, "len0");
    directed_burst(5, 16, 1'b1, "wrap16");

    // Reset in the middle of a burst
    start_burst(0, 16);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_rd_busy", bus.rd_busy, 0);
    check("midrst_rd_done", bus.rd_done, 0);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1;
    directed_burst(9, 5, 1'b1, "post_rst");

    // Randomized traffic
    ready_mode = 2;
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 2));
      if (op == 0) begin
        do_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), w);
      end else begin
        start_burst(int'($urandom_range(0, 15)), int'($urandom_range(0, 16)));
        if (op == 2) do_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), w);
        wait_idle();
      end
    end
    ready_mode = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
